// File: rtl/button_pulse.sv
// button_pulse: conditions four raw push-buttons into clean direction pulses.
// Each button goes through a 2-flop synchroniser, a debounce counter, a
// rising-edge one-shot and an optional auto-repeat timer. If opposing
// directions (up/down, left/right) would pulse in the same cycle, both
// are dropped. Bit order everywhere is {up, down, left, right}.
module button_pulse #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_DELAY    = 8,
  parameter int unsigned REPEAT_PERIOD   = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic [3:0] held
);

  localparam int unsigned NumBtn = 4;

  // Debounce counter only has to reach DEBOUNCE_CYCLES-1 before the level flips.
  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);

  // One hold counter serves both the initial delay and the repeat period.
  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                   : REPEAT_PERIOD;
  localparam int unsigned RepW = $clog2(RepMax + 1);
  localparam logic [RepW-1:0] DelayLast  = RepW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [RepW-1:0] PeriodLast = RepW'(REPEAT_PERIOD - 1);
  localparam bit RepeatEn = (REPEAT_DELAY != 0);

  logic [NumBtn-1:0] raw;

  logic [NumBtn-1:0] sync1_q, sync1_d;
  logic [NumBtn-1:0] sync2_q, sync2_d;

  logic [NumBtn-1:0] level_q, level_d;
  logic [DbW-1:0]    db_cnt_q [NumBtn];
  logic [DbW-1:0]    db_cnt_d [NumBtn];
  logic [NumBtn-1:0] press;
  logic [NumBtn-1:0] rel_evt;

  logic [RepW-1:0]   rep_cnt_q [NumBtn];
  logic [RepW-1:0]   rep_cnt_d [NumBtn];
  // Clear while waiting for the first repeat, set once in the periodic phase.
  logic [NumBtn-1:0] rep_phase_q, rep_phase_d;
  logic [NumBtn-1:0] rep_fire;

  logic [NumBtn-1:0] pulse;
  logic [NumBtn-1:0] out_q, out_d;

  assign raw = {btn_up, btn_down, btn_left, btn_right};

  // Synchroniser next state: two plain delay stages.
  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
  end

  // Synchroniser flops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  // Debounce: accept a new level after DEBOUNCE_CYCLES consecutive mismatches.
  always_comb begin
    level_d = level_q;
    press   = '0;
    rel_evt = '0;
    for (int i = 0; i < NumBtn; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DbLast) begin
          level_d[i] = sync2_q[i];
          press[i]   = sync2_q[i];
          rel_evt[i] = ~sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
        end
      end
    end
  end

  // Debounce flops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      level_q <= '0;
      for (int i = 0; i < NumBtn; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      level_q <= level_d;
      for (int i = 0; i < NumBtn; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  // Auto-repeat: counter runs only while the debounced level is high and not
  // being released on this edge; it is zero on the press edge itself.
  always_comb begin
    rep_phase_d = '0;
    rep_fire    = '0;
    for (int i = 0; i < NumBtn; i++) begin
      rep_cnt_d[i] = '0;
      if (RepeatEn && level_q[i] && !rel_evt[i]) begin
        rep_phase_d[i] = rep_phase_q[i];
        rep_cnt_d[i]   = rep_cnt_q[i] + RepW'(1);
        if (!rep_phase_q[i]) begin
          if (rep_cnt_q[i] == DelayLast) begin
            rep_fire[i]    = 1'b1;
            rep_cnt_d[i]   = '0;
            rep_phase_d[i] = 1'b1;
          end
        end else if (rep_cnt_q[i] == PeriodLast) begin
          rep_fire[i]  = 1'b1;
          rep_cnt_d[i] = '0;
        end
      end
    end
  end

  // Auto-repeat flops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rep_phase_q <= '0;
      for (int i = 0; i < NumBtn; i++) begin
        rep_cnt_q[i] <= '0;
      end
    end else begin
      rep_phase_q <= rep_phase_d;
      for (int i = 0; i < NumBtn; i++) begin
        rep_cnt_q[i] <= rep_cnt_d[i];
      end
    end
  end

  // Merge press and repeat pulses, then cancel opposing directions.
  always_comb begin
    pulse    = press | rep_fire;
    out_d[3] = pulse[3] & ~pulse[2];
    out_d[2] = pulse[2] & ~pulse[3];
    out_d[1] = pulse[1] & ~pulse[0];
    out_d[0] = pulse[0] & ~pulse[1];
  end

  // Registered direction pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign up    = out_q[3];
  assign down  = out_q[2];
  assign left  = out_q[1];
  assign right = out_q[0];
  assign held  = level_q;

endmodule

// File: tb/tb_button_pulse.sv
// Randomised and directed bench for button_pulse against a history-based
// reference model: the debounced level flips when the last DEBOUNCE_CYCLES
// synchronised samples all differ from it, and repeats fire at fixed ages
// since the press.
module tb_button_pulse;

  localparam int Deb    = 4;
  localparam int Delay  = 8;
  localparam int Period = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] raw;
  logic       up, down, left, right;
  logic [3:0] held;

  button_pulse #(
    .DEBOUNCE_CYCLES(Deb),
    .REPEAT_DELAY   (Delay),
    .REPEAT_PERIOD  (Period)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .btn_up   (raw[3]),
    .btn_down (raw[2]),
    .btn_left (raw[1]),
    .btn_right(raw[0]),
    .up       (up),
    .down     (down),
    .left     (left),
    .right    (right),
    .held     (held)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [3:0] rawh[$];      // raw value sampled at each edge since reset
  int         n_edge;
  logic [3:0] m_d;
  logic [3:0] m_out;
  int         press_edge[4];
  int         pulse_cnt[4]; // observed pulses, index 3 = up

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (edge %0d)", tag, got, exp, n_edge);
    end
  endtask

  // Synchronised value seen at edge m is the raw level sampled two edges earlier.
  function automatic logic s_at(input int m, input int b);
    logic [3:0] v;
    if (m < 2) return 1'b0;
    v = rawh[m-2];
    return v[b];
  endfunction

  task automatic model_reset();
    rawh.delete();
    n_edge = 0;
    m_d    = '0;
    m_out  = '0;
    for (int b = 0; b < 4; b++) press_edge[b] = 0;
  endtask

  task automatic model_step();
    logic [3:0] nd, pulse;
    bit all_diff, rel;
    int age;
    rawh.push_back(raw);
    nd    = m_d;
    pulse = '0;
    for (int b = 0; b < 4; b++) begin
      rel      = 1'b0;
      all_diff = 1'b1;
      for (int k = 0; k < Deb; k++) begin
        if (s_at(n_edge - k, b) == m_d[b]) all_diff = 1'b0;
      end
      if (all_diff) begin
        nd[b] = ~m_d[b];
        if (nd[b]) begin
          pulse[b]      = 1'b1;
          press_edge[b] = n_edge;
        end else begin
          rel = 1'b1;
        end
      end
      if (Delay > 0 && m_d[b] && !rel) begin
        age = n_edge - press_edge[b];
        if (age == Delay || (age > Delay && (age - Delay) % Period == 0)) pulse[b] = 1'b1;
      end
    end
    m_out[3] = pulse[3] && !pulse[2];
    m_out[2] = pulse[2] && !pulse[3];
    m_out[1] = pulse[1] && !pulse[0];
    m_out[0] = pulse[0] && !pulse[1];
    m_d = nd;
    n_edge++;
  endtask

  // One clock edge with the current raw inputs; check at the falling edge.
  task automatic tick();
    logic [3:0] o;
    @(posedge clock);
    model_step();
    @(negedge clock);
    check("outputs", {up, down, left, right, held}, {m_out, m_d});
    o = {up, down, left, right};
    for (int b = 0; b < 4; b++) if (o[b]) pulse_cnt[b]++;
  endtask

  // Assert reset at a falling edge for a number of cycles; outputs must clear at once.
  task automatic do_reset(input int cycles);
    reset = 1'b1;
    #1;
    check("reset_async", {up, down, left, right, held}, 8'h00);
    model_reset();
    for (int c = 0; c < cycles; c++) begin
      @(negedge clock);
      check("reset_hold", {up, down, left, right, held}, 8'h00);
    end
    reset = 1'b0;
  endtask

  task automatic clear_counts();
    for (int b = 0; b < 4; b++) pulse_cnt[b] = 0;
  endtask

  logic [3:0] target;
  logic [3:0] glitch;
  int         bounce_r [10];
  int         bounce_f [10];

  initial begin
    reset = 1'b0;
    raw   = '0;
    model_reset();
    clear_counts();
    @(negedge clock);
    do_reset(2);

    // Idle: nothing may move.
    repeat (20) tick();

    // Single press of up: exactly one pulse before the first repeat point.
    clear_counts();
    raw = 4'b1000;
    repeat (12) tick();
    check("up_single_pulse", 8'(pulse_cnt[3]), 8'd1);
    raw = 4'b0000;
    repeat (12) tick();

    // Right with bouncy press and release.
    bounce_r = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1};
    bounce_f = '{0, 1, 0, 0, 1, 0, 0, 0, 0, 0};
    clear_counts();
    for (int i = 0; i < 5; i++) begin
      raw = {3'b000, 1'(bounce_r[i])};
      tick();
    end
    raw = 4'b0001;
    repeat (12) tick();
    check("right_bounce_one_pulse", 8'(pulse_cnt[0]), 8'd1);
    for (int i = 0; i < 10; i++) begin
      raw = {3'b000, 1'(bounce_f[i])};
      tick();
    end
    repeat (6) tick();

    // Left held 30 cycles: press pulse plus six repeats.
    clear_counts();
    raw = 4'b0010;
    repeat (30) tick();
    raw = 4'b0000;
    repeat (10) tick();
    check("left_repeat_count", 8'(pulse_cnt[1]), 8'd7);

    // Up and down together cancel; held still shows both.
    clear_counts();
    raw = 4'b1100;
    repeat (20) tick();
    check("updown_cancel", 8'(pulse_cnt[3] + pulse_cnt[2]), 8'd0);
    check("updown_held", {4'h0, held}, 8'h0c);
    raw = 4'b0000;
    repeat (10) tick();

    // Up and right are not opposing: both pulse.
    clear_counts();
    raw = 4'b1001;
    repeat (8) tick();
    check("upright_pass", {8'(pulse_cnt[3]) + 8'(pulse_cnt[0])}, 8'd2);
    raw = 4'b0000;
    repeat (10) tick();

    // Down held, reset mid-repeat, then a fresh press after reset release.
    raw = 4'b0100;
    repeat (20) tick();
    do_reset(3);
    clear_counts();
    repeat (8) tick();
    check("down_after_reset", 8'(pulse_cnt[2]), 8'd1);
    raw = 4'b0000;
    repeat (10) tick();

    // Random levels with occasional bounces and rare resets.
    target = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 24) == 0) target[b] = ~target[b];
        glitch[b] = ($urandom_range(0, 9) == 0);
      end
      raw = target ^ glitch;
      tick();
      if ($urandom_range(0, 599) == 0) do_reset($urandom_range(1, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
